// File: rtl/picobello_pkg.sv
// rtl/picobello_pkg.sv - shared serial-link TX types, widths and helpers
package picobello_pkg;

  // Channel-side flit layout for the default link configuration.
  localparam int unsigned SlinkDataWidth = 64;
  localparam int unsigned SlinkMaxReq    = 16;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SlinkIdxW = idx_w(SlinkMaxReq);

  typedef struct packed {
    logic [SlinkDataWidth-1:0] data;
    logic                      last;
    logic [SlinkIdxW-1:0]      src;
  } slink_flit_t;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pb_rr_select.sv
// rtl/pb_rr_select.sv - first eligible requester at or above a round-robin pointer
module pb_rr_select #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  logic [IdxW:0] pos;

  // Walk NumReq positions from the pointer, wrapping; the first eligible one wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = {1'b0, ptr_i} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(NumReq)) begin
        pos = pos - (IdxW+1)'(NumReq);
      end
      if (!found_o && eligible_i[pos[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/pb_slink_tx_arb.sv
// rtl/pb_slink_tx_arb.sv - packet-locked round-robin arbiter onto one serial-link TX channel
module pb_slink_tx_arb
  import picobello_pkg::*;
#(
  parameter int unsigned  NumReq    = 4,
  parameter int unsigned  DataWidth = 64,
  localparam int unsigned IdxW      = idx_w(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           en_mask_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        out_valid_o,
  output logic [DataWidth-1:0]        out_data_o,
  output logic                        out_last_o,
  output logic [IdxW-1:0]             out_src_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic [15:0]                 pkt_cnt_o
);

  arb_state_e           state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [IdxW-1:0]      lock_idx_q;
  // Set for the one cycle after a locked packet ends so the next grant leaves a bubble.
  logic                 gap_q;
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;
  logic                 out_last_q;
  logic [IdxW-1:0]      out_src_q;
  logic [15:0]          pkt_cnt_q;
  logic [15:0]          pkt_cnt_d;

  logic                 can_accept;
  logic [NumReq-1:0]    eligible;
  logic [IdxW-1:0]      sel_idx;
  logic                 sel_found;
  logic [IdxW-1:0]      grant_idx;
  logic                 hs;
  logic                 hs_last;
  logic [DataWidth-1:0] hs_data;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NumReq - 1)) ? '0 : i + 1'b1;
  endfunction

  assign eligible = req_valid_i & en_mask_i;

  pb_rr_select #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_select (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .idx_o      (sel_idx),
    .found_o    (sel_found)
  );

  // Grant: the lock owner while LOCKED, otherwise the round-robin pick; gated by buffer space.
  always_comb begin
    can_accept  = !out_valid_q || out_ready_i;
    req_ready_o = '0;
    grant_idx   = sel_idx;
    if (state_q == ArbLocked) begin
      grant_idx = lock_idx_q;
    end
    if (rst_ni) begin
      if (state_q == ArbLocked) begin
        req_ready_o[lock_idx_q] = can_accept;
      end else if (sel_found && !gap_q) begin
        req_ready_o[sel_idx] = can_accept;
      end
    end
    hs      = |(req_valid_i & req_ready_o);
    hs_last = req_last_i[grant_idx];
    hs_data = req_data_i[32'(grant_idx)*DataWidth +: DataWidth];
  end

  // Packet lock FSM with the round-robin pointer and owner index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      gap_q      <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      case (state_q)
        ArbIdle: begin
          if (hs) begin
            if (hs_last) begin
              rr_ptr_q <= next_idx(sel_idx);
            end else begin
              state_q    <= ArbLocked;
              lock_idx_q <= sel_idx;
            end
          end
        end
        ArbLocked: begin
          if (hs && hs_last) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= next_idx(lock_idx_q);
            gap_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  // One-entry output buffer: load on handshake, drain when the channel accepts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else if (hs) begin
      out_valid_q <= 1'b1;
      out_data_q  <= hs_data;
      out_last_q  <= hs_last;
      out_src_q   <= grant_idx;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // A packet counts as sent once its last flit leaves the buffer.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (out_valid_q && out_ready_i && out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Sent-packet counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_src_o   = out_src_q;
  assign busy_o      = (state_q == ArbLocked) || out_valid_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule
